alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Control-side counterpart of the ALU: fetches instructions, decodes them, issues alu_op,
//  sequences register-file read/write strobes and consumes the ALU z flag for branches.
//  Sits between instruction memory, register file and ALU in the CSD processor datapath.
//  Respects ALU timing: alu_out registered 1 edge after alu_op, z valid 1 edge later.
// PARAMETERS
//  IW   16  instruction width; fields [15:12] opcode, [11:8] rd, [7:4] ra, [3:0] rb / [7:0] target
//  AW   8   program counter / instruction address width
//  RW   4   register-file address width
// PORTS
//  clk       in   1   single clock, rising edge
//  rst       in   1   asynchronous, active-high reset
//  start     in   1   1-cycle pulse; starts execution (honoured only in IDLE/HALTED)
//  im_addr   out  AW  instruction memory address (=pc)
//  im_rd_en  out  1   instruction memory read strobe (sync read, data next cycle)
//  im_data   in   IW  instruction memory read data
//  alu_op    out  3   1 add, 2 sub, 3 shl, 4 shr, 0 = no op
//  z         in   16  ALU zero flag; only z[0] used
//  reg_ra    out  RW  register-file read address A (ALU in1)
//  reg_rb    out  RW  register-file read address B (ALU in2)
//  reg_wa    out  RW  register-file write address
//  reg_we    out  1   register-file write enable (1-cycle pulse)
//  busy      out  1   high in every state except IDLE/HALTED
//  done      out  1   high while HALTED
// BEHAVIOUR
//  - All outputs registered. rst (async, any cycle, mid-instruction included): state=IDLE,
//    pc=0, ir=0, zflag=0, all outputs 0. No partial write survives reset.
//  - Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 SHL, 4 SHR, 5 JMPZ, 6 JMP, 7 HALT, 8-15 treated as NOP.
//  - States: IDLE, FETCH, DECODE, EXEC, WAIT, WB, HALTED.
//  - IDLE: start=1 -> FETCH (pc stays 0). HALTED: done=1; start=1 -> pc=0, FETCH.
//    start in any other state ignored.
//  - FETCH (1 cyc): im_addr=pc, im_rd_en=1 -> DECODE.
//  - DECODE (1 cyc): ir<=im_data; reg_ra=ir[7:4], reg_rb=ir[3:0] valid from here -> EXEC.
//  - EXEC, ALU ops 1-4: alu_op=opcode for exactly this cycle -> WAIT.
//  - EXEC, JMP: pc<=ir[7:0]; JMPZ: pc<=ir[7:0] if zflag else pc+1; NOP/undef: pc+1;
//    all -> FETCH, alu_op stays 0. HALT: -> HALTED, pc unchanged.
//  - WAIT (1 cyc): alu_op=0; ALU latches result at end of EXEC, z updates at end of WAIT -> WB.
//  - WB (1 cyc): reg_we=1, reg_wa=ir[11:8]; zflag<=z[0]; pc<=pc+1 -> FETCH.
//  - Latency: ALU instr 5 cycles, branch/NOP 3 cycles, FETCH to FETCH.
//  - reg_ra/reg_rb held from DECODE through WB; reg_we never high outside WB.
//  - pc arithmetic modulo 2^AW: pc=2^AW-1 increments to 0. Only ALU ops update zflag.
// STRUCTURE
//  - Shared package csd_pkg: opcode localparams (OP_NOP..OP_HALT), ALU op codes
//    (ALU_NOP/ADD/SUB/SHL/SHR), state encoding localparams.
//  - Single module; no sub-module needed (decode is a small case inside EXEC).
// TESTING
//  - Reset: assert rst mid-WB -> reg_we=0, alu_op=0, busy=0, pc=0 same cycle, before next edge.
//  - ADD r3=r1+r2 (16'h1312) at pc 0: start -> alu_op=1 for 1 cycle in EXEC, reg_we=1 with
//    reg_wa=3 exactly 2 cycles later, im_addr=1 on next FETCH.
//  - SUB r4=r1-r1 with ALU model giving 0 -> zflag=1; next JMPZ 8'h20 (16'h5020) -> im_addr=20.
//  - ADD giving nonzero, then JMPZ 8'h20 -> not taken, im_addr=pc+1; JMP 8'h00 always taken.
//  - HALT (16'h7000): done=1, busy=0, no further im_rd_en; start pulse -> FETCH at im_addr=0.
//  - Wrap: JMP 8'hFF, NOP at FF -> next im_addr=00; opcode 4'hB behaves as NOP, reg_we stays 0.

Source files
------------

// File: rtl/csd_pkg.sv
// ---------------------------------------------------------------------------
// csd_pkg -- shared definitions for the CSD processor control path.
//   * Instruction opcodes (OP_*), the 4-bit field at ir[15:12].
//   * ALU operation codes (ALU_*) driven on alu_op.
//   * Sequencer state encoding (ST_* values, state_t enum).
//   * alu_code(): maps an instruction opcode to its ALU operation.
// ---------------------------------------------------------------------------
package csd_pkg;

    // Instruction opcodes; 8-15 are undefined and execute as NOP.
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SHL  = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_JMPZ = 4'd5;
    localparam logic [3:0] OP_JMP  = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd7;

    // ALU operation codes.
    localparam logic [2:0] ALU_NOP = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_SHL = 3'd3;
    localparam logic [2:0] ALU_SHR = 3'd4;

    // Sequencer state encoding.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALTED = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_WAIT   = ST_WAIT,
        S_WB     = ST_WB,
        S_HALTED = ST_HALTED
    } state_t;

    // ALU operation for an opcode; non-ALU opcodes map to ALU_NOP.
    function automatic logic [2:0] alu_code(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_SHL:  return ALU_SHL;
            OP_SHR:  return ALU_SHR;
            default: return ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer -- instruction fetch/decode/execute controller for the ALU.
//
// Fetches instructions from a synchronous-read instruction memory, decodes
// them, issues alu_op, sequences register-file read/write strobes and uses
// the ALU zero flag (captured from z[0] on write-back) for conditional jumps.
//
// Ports
//   clk       in   1   rising-edge clock
//   rst       in   1   asynchronous active-high reset
//   start     in   1   start pulse, honoured in IDLE and HALTED only
//   im_addr   out  AW  instruction memory address (tracks pc)
//   im_rd_en  out  1   instruction memory read strobe (high in FETCH)
//   im_data   in   IW  instruction memory read data (valid the cycle after FETCH)
//   alu_op    out  3   ALU operation, non-zero only during EXEC of ALU ops
//   z         in   16  ALU zero flag, only bit 0 is used
//   reg_ra    out  RW  register-file read address A
//   reg_rb    out  RW  register-file read address B
//   reg_wa    out  RW  register-file write address
//   reg_we    out  1   register-file write enable, high only in WB
//   busy      out  1   high outside IDLE/HALTED
//   done      out  1   high while HALTED
//
// Every output is a flop loaded from the value it must carry in the next
// state, so each output is valid for the whole cycle of the state it belongs
// to. Cycle counts FETCH to FETCH: ALU ops 5, branches/NOP 3.
// ---------------------------------------------------------------------------
module alu_sequencer
    import csd_pkg::*;
#(
    parameter int IW = 16,
    parameter int AW = 8,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] im_addr,
    output logic          im_rd_en,
    input  logic [IW-1:0] im_data,
    output logic [2:0]    alu_op,
    input  logic [15:0]   z,
    output logic [RW-1:0] reg_ra,
    output logic [RW-1:0] reg_rb,
    output logic [RW-1:0] reg_wa,
    output logic          reg_we,
    output logic          busy,
    output logic          done
);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] ir_q, ir_d;
    logic          zflag_q, zflag_d;

    logic [2:0]    alu_op_d;
    logic          im_rd_en_d;
    logic [RW-1:0] reg_ra_d, reg_rb_d, reg_wa_d;
    logic          reg_we_d;

    // Instruction fields.
    logic [3:0]    ir_opcode;
    logic [RW-1:0] ir_rd;
    logic [AW-1:0] ir_target;
    logic [3:0]    im_opcode;

    assign ir_opcode = ir_q[IW-1 -: 4];
    assign ir_rd     = ir_q[IW-5 -: RW];
    assign ir_target = ir_q[AW-1:0];
    assign im_opcode = im_data[IW-1 -: 4];

    // Only the zero bit of the ALU flag word is meaningful here.
    logic unused_z;
    assign unused_z = ^z[15:1];

    // -----------------------------------------------------------------------
    // Next-state and next-output logic.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; that is what keeps this block free of latches.
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        zflag_d    = zflag_q;
        alu_op_d   = ALU_NOP;
        im_rd_en_d = 1'b0;
        reg_we_d   = 1'b0;
        reg_wa_d   = reg_wa;
        reg_ra_d   = reg_ra;
        reg_rb_d   = reg_rb;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_HALTED: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                // Instruction word arrives this cycle; register it together with
                // the read addresses and the ALU op so all are valid in EXEC.
                ir_d     = im_data;
                reg_ra_d = im_data[2*RW-1 -: RW];
                reg_rb_d = im_data[RW-1:0];
                alu_op_d = alu_code(im_opcode);
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                case (ir_opcode)
                    OP_ADD, OP_SUB, OP_SHL, OP_SHR: state_d = S_WAIT;
                    OP_JMP: begin
                        pc_d    = ir_target;
                        state_d = S_FETCH;
                    end
                    OP_JMPZ: begin
                        pc_d    = zflag_q ? ir_target : pc_q + AW'(1);
                        state_d = S_FETCH;
                    end
                    OP_HALT: state_d = S_HALTED;
                    default: begin
                        pc_d    = pc_q + AW'(1);
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_WAIT: begin
                // ALU result latched at the end of EXEC; the write strobe is
                // staged here so it appears exactly in WB.
                reg_we_d = 1'b1;
                reg_wa_d = ir_rd;
                state_d  = S_WB;
            end
            S_WB: begin
                // z settled at the end of WAIT, so it is stable across WB.
                zflag_d = z[0];
                pc_d    = pc_q + AW'(1);
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_FETCH) im_rd_en_d = 1'b1;
    end

    // -----------------------------------------------------------------------
    // State and output registers.
    // -----------------------------------------------------------------------
    // NOTE: every flop here, outputs included, is cleared by the async reset so
    // an in-flight write strobe is dropped the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            zflag_q  <= 1'b0;
            im_addr  <= '0;
            im_rd_en <= 1'b0;
            alu_op   <= ALU_NOP;
            reg_ra   <= '0;
            reg_rb   <= '0;
            reg_wa   <= '0;
            reg_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            zflag_q  <= zflag_d;
            im_addr  <= pc_d;
            im_rd_en <= im_rd_en_d;
            alu_op   <= alu_op_d;
            reg_ra   <= reg_ra_d;
            reg_rb   <= reg_rb_d;
            reg_wa   <= reg_wa_d;
            reg_we   <= reg_we_d;
            busy     <= (state_d != S_IDLE) && (state_d != S_HALTED);
            done     <= (state_d == S_HALTED);
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer -- directed self-checking bench for alu_sequencer.
// Surrounds the sequencer with a synchronous instruction memory, a 16-entry
// register file and an ALU whose result registers one edge after alu_op and
// whose zero flag follows one edge later.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  im_addr;
    logic        im_rd_en;
    logic [15:0] im_data = '0;
    logic [2:0]  alu_op;
    logic [15:0] z = '0;
    logic [3:0]  reg_ra, reg_rb, reg_wa;
    logic        reg_we, busy, done;

    alu_sequencer #(.IW(16), .AW(8), .RW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .im_addr  (im_addr),
        .im_rd_en (im_rd_en),
        .im_data  (im_data),
        .alu_op   (alu_op),
        .z        (z),
        .reg_ra   (reg_ra),
        .reg_rb   (reg_rb),
        .reg_wa   (reg_wa),
        .reg_we   (reg_we),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Environment: instruction memory, register file, ALU.
    logic [15:0] mem [256];
    logic [15:0] regs [16] = '{1: 16'd5, 2: 16'd7, default: 16'd0};
    logic [15:0] alu_out = '0;
    logic        z_pend  = 1'b0;

    always @(posedge clk) begin
        if (im_rd_en) im_data <= mem[im_addr];
        if (alu_op != 3'd0) begin
            case (alu_op)
                3'd1:    alu_out <= regs[reg_ra] + regs[reg_rb];
                3'd2:    alu_out <= regs[reg_ra] - regs[reg_rb];
                3'd3:    alu_out <= regs[reg_ra] << regs[reg_rb][3:0];
                default: alu_out <= regs[reg_ra] >> regs[reg_rb][3:0];
            endcase
            z_pend <= 1'b1;
        end else begin
            z_pend <= 1'b0;
        end
        if (z_pend) z <= {15'h0, alu_out == 16'd0};
        if (reg_we) regs[reg_wa] <= alu_out;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Per-instruction observations, FETCH (cycle 0) to the next FETCH/HALTED.
    int         cyc, alu_cnt, alu_at, we_cnt, we_at;
    logic [2:0] alu_seen;
    logic [3:0] wa_seen, ra_seen, rb_seen;

    task automatic run_instr();
        cyc = 0; alu_cnt = 0; alu_at = -1; we_cnt = 0; we_at = -1;
        alu_seen = '0; wa_seen = '0; ra_seen = '0; rb_seen = '0;
        do begin
            @(negedge clk);
            cyc++;
            if (alu_op != 3'd0) begin
                alu_cnt++; alu_at = cyc; alu_seen = alu_op;
                ra_seen = reg_ra; rb_seen = reg_rb;
            end
            if (reg_we) begin
                we_cnt++; we_at = cyc; wa_seen = reg_wa;
            end
        end while (!im_rd_en && !done && cyc < 20);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    int rd_cnt;

    initial begin
        foreach (mem[i]) mem[i] = 16'h0000;
        mem[8'h00] = 16'h1312;  // ADD r3 = r1 + r2 (12)
        mem[8'h01] = 16'h5020;  // JMPZ 20, zflag=0 -> not taken
        mem[8'h02] = 16'h2411;  // SUB r4 = r1 - r1 (0) -> zflag=1
        mem[8'h03] = 16'h5020;  // JMPZ 20, taken
        mem[8'h20] = 16'h6030;  // JMP 30
        mem[8'h30] = 16'h5040;  // JMPZ 40, zflag still 1 -> taken
        mem[8'h40] = 16'h7000;  // HALT

        // Reset state.
        #1 rst = 1'b1;
        #3;
        check("rst_im_addr",  32'(im_addr),  0);
        check("rst_im_rd_en", 32'(im_rd_en), 0);
        check("rst_alu_op",   32'(alu_op),   0);
        check("rst_reg_we",   32'(reg_we),   0);
        check("rst_busy",     32'(busy),     0);
        check("rst_done",     32'(done),     0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Phase 1: ALU ops, conditional and unconditional branches, HALT.
        pulse_start();
        check("start_fetch_rd_en", 32'(im_rd_en), 1);
        check("start_fetch_addr",  32'(im_addr),  0);
        check("start_busy",        32'(busy),     1);

        run_instr();  // ADD
        check("add_cycles",   32'(cyc),      5);
        check("add_alu_cnt",  32'(alu_cnt),  1);
        check("add_alu_op",   32'(alu_seen), 1);
        check("add_alu_at",   32'(alu_at),   2);
        check("add_ra",       32'(ra_seen),  1);
        check("add_rb",       32'(rb_seen),  2);
        check("add_we_cnt",   32'(we_cnt),   1);
        check("add_we_at",    32'(we_at),    4);
        check("add_wa",       32'(wa_seen),  3);
        check("add_next_pc",  32'(im_addr),  1);
        check("add_r3",       32'(regs[3]),  12);

        run_instr();  // JMPZ not taken
        check("jmpz_nt_cycles", 32'(cyc),     3);
        check("jmpz_nt_alu",    32'(alu_cnt), 0);
        check("jmpz_nt_we",     32'(we_cnt),  0);
        check("jmpz_nt_pc",     32'(im_addr), 2);

        run_instr();  // SUB -> zero
        check("sub_cycles",  32'(cyc),      5);
        check("sub_alu_op",  32'(alu_seen), 2);
        check("sub_wa",      32'(wa_seen),  4);
        check("sub_next_pc", 32'(im_addr),  3);
        check("sub_r4",      32'(regs[4]),  0);

        run_instr();  // JMPZ taken
        check("jmpz_t_cycles", 32'(cyc),     3);
        check("jmpz_t_pc",     32'(im_addr), 32'h20);

        run_instr();  // JMP 30
        check("jmp_pc",        32'(im_addr), 32'h30);

        run_instr();  // JMPZ again: branches leave zflag alone
        check("jmpz_keep_z_pc", 32'(im_addr), 32'h40);

        run_instr();  // HALT
        check("halt_cycles", 32'(cyc),      3);
        check("halt_done",   32'(done),     1);
        check("halt_busy",   32'(busy),     0);
        rd_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (im_rd_en) rd_cnt++;
        end
        check("halt_no_fetch", 32'(rd_cnt), 0);
        check("halt_done_hold", 32'(done), 1);

        // Phase 2: restart from HALTED, pc wrap, undefined opcode as NOP.
        mem[8'h00] = 16'h60FF;  // JMP FF
        mem[8'hFF] = 16'hB000;  // undefined -> NOP
        pulse_start();
        check("restart_addr", 32'(im_addr), 0);
        check("restart_done", 32'(done),    0);
        check("restart_busy", 32'(busy),    1);

        run_instr();  // JMP FF
        check("jmp_ff_pc", 32'(im_addr), 32'hFF);
        mem[8'h00] = 16'h7000;  // HALT once the wrap lands on 00

        run_instr();  // opcode B
        check("undef_cycles", 32'(cyc),     3);
        check("undef_alu",    32'(alu_cnt), 0);
        check("undef_we",     32'(we_cnt),  0);
        check("wrap_pc",      32'(im_addr), 0);

        run_instr();  // HALT
        check("halt2_done", 32'(done), 1);

        // Phase 3: reset in the middle of a write-back.
        mem[8'h00] = 16'h1512;  // ADD r5 = r1 + r2
        pulse_start();
        repeat (3) @(negedge clk);  // DECODE, EXEC, WAIT
        @(posedge clk);
        #1;
        check("wb_before_rst", 32'(reg_we), 1);
        rst = 1'b1;
        #1;
        check("midwb_reg_we",  32'(reg_we),   0);
        check("midwb_alu_op",  32'(alu_op),   0);
        check("midwb_busy",    32'(busy),     0);
        check("midwb_pc",      32'(im_addr),  0);
        check("midwb_rd_en",   32'(im_rd_en), 0);
        check("midwb_done",    32'(done),     0);
        @(posedge clk);
        #1;
        check("midwb_no_write", 32'(regs[5]), 0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
